// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared constants and state encoding for the fetch stage
//
// Purpose: default widths, the halt instruction encoding and the fetch FSM states.
// Ports:   none (package).
package instr_fetch_unit_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_DATA_W-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  // 2'd3 is unused; the FSM falls back to IDLE if it ever appears.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// rtl/instr_fetch_unit_pc_reg.sv - program counter with load, increment and hold
//
// Purpose: holds the fetch PC; load wins over increment, increment wraps silently.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, loads RESET_PC
//   load       in   load load_addr this cycle
//   load_addr  in   ADDR_W  value for load
//   inc        in   advance PC by one (modulo 2**ADDR_W)
//   pc         out  ADDR_W  current program counter
module instr_fetch_unit_pc_reg #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + ONE;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, IDLE/RUN/HALTED FSM and IF/ID register
//
// Purpose: addresses the zero-latency instruction memory with the PC and captures
//          the returned word into the IF/ID register under a valid/ready handshake.
// Ports:
//   CLK            in   clock, rising edge
//   RST            in   synchronous active-high reset
//   START          in   one-cycle pulse, leaves IDLE
//   IMEM_A         out  ADDR_W  instruction memory word address (= PC)
//   IMEM_RD        in   DATA_W  combinational read data
//   REDIRECT       in   load PC from REDIRECT_ADDR, flush IF/ID
//   REDIRECT_ADDR  in   ADDR_W  redirect target
//   ID_READY       in   decoder accepts INSTR this cycle
//   INSTR          out  DATA_W  IF/ID instruction
//   INSTR_PC       out  ADDR_W  address INSTR came from
//   INSTR_VALID    out  INSTR is valid
//   HALTED         out  FSM is in HALTED
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic [ADDR_W-1:0] IMEM_A,
  input  logic [DATA_W-1:0] IMEM_RD,
  input  logic              REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_ADDR,
  input  logic              ID_READY,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] INSTR_PC,
  output logic              INSTR_VALID,
  output logic              HALTED
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc;
  logic              pc_load, pc_inc;
  logic              capture;
  logic              valid_next;
  logic              slot_free;

  instr_fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (CLK),
    .rst       (RST),
    .load      (pc_load),
    .load_addr (REDIRECT_ADDR),
    .inc       (pc_inc),
    .pc        (pc)
  );

  assign IMEM_A    = pc;
  assign slot_free = !INSTR_VALID || ID_READY;
  assign HALTED    = (state == ST_HALTED);

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    capture    = 1'b0;
    valid_next = INSTR_VALID;
    case (state)
      ST_IDLE: begin
        pc_load    = REDIRECT;
        valid_next = 1'b0;
        if (START) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (REDIRECT) begin
          // Wrong-path word is dropped even if decode never took it.
          pc_load    = 1'b1;
          valid_next = 1'b0;
        end else if (slot_free) begin
          capture    = 1'b1;
          valid_next = 1'b1;
          // The halt word is delivered but the PC parks on its address.
          if (IMEM_RD == HALT_WORD) state_next = ST_HALTED;
          else                      pc_inc     = 1'b1;
        end
      end
      ST_HALTED: begin
        if (REDIRECT) begin
          pc_load    = 1'b1;
          valid_next = 1'b0;
          state_next = ST_RUN;
        end else if (INSTR_VALID && ID_READY) begin
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      INSTR       <= '0;
      INSTR_PC    <= '0;
      INSTR_VALID <= 1'b0;
    end else begin
      state       <= state_next;
      INSTR_VALID <= valid_next;
      if (capture) begin
        INSTR    <= IMEM_RD;
        INSTR_PC <= pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  IMEM_A;
  logic [31:0] IMEM_RD;
  logic        REDIRECT = 1'b0;
  logic [7:0]  REDIRECT_ADDR = 8'h00;
  logic        ID_READY = 1'b1;
  logic [31:0] INSTR;
  logic [7:0]  INSTR_PC;
  logic        INSTR_VALID;
  logic        HALTED;

  logic [31:0] mem [256];
  assign IMEM_RD = mem[IMEM_A];

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: mode, PC as an integer, IF/ID contents.
  int          m_mode = M_IDLE;
  int          m_pc = 0;
  logic [31:0] m_instr = '0;
  int          m_ipc = 0;
  logic        m_valid = 1'b0;

  instr_fetch_unit dut (
    .CLK           (CLK),
    .RST           (RST),
    .START         (START),
    .IMEM_A        (IMEM_A),
    .IMEM_RD       (IMEM_RD),
    .REDIRECT      (REDIRECT),
    .REDIRECT_ADDR (REDIRECT_ADDR),
    .ID_READY      (ID_READY),
    .INSTR         (INSTR),
    .INSTR_PC      (INSTR_PC),
    .INSTR_VALID   (INSTR_VALID),
    .HALTED        (HALTED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // What the next rising edge should do, stated from the behavioural rules.
  task automatic model_edge();
    bit accepted;
    accepted = m_valid && ID_READY;
    if (RST) begin
      m_mode = M_IDLE; m_pc = 0; m_instr = '0; m_ipc = 0; m_valid = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (REDIRECT) m_pc = REDIRECT_ADDR;
      if (START) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (REDIRECT) begin
        m_pc = REDIRECT_ADDR; m_valid = 1'b0;
      end else if (!m_valid || ID_READY) begin
        m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
        if (mem[m_pc] == HALT) m_mode = M_HALTED;
        else m_pc = (m_pc + 1) % 256;
      end
    end else begin
      if (REDIRECT) begin
        m_pc = REDIRECT_ADDR; m_valid = 1'b0; m_mode = M_RUN;
      end else if (accepted) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    chk("model_imem_a", 32'(IMEM_A), 32'(m_pc));
    chk("model_valid", 32'(INSTR_VALID), 32'(m_valid));
    chk("model_halted", 32'(HALTED), 32'(m_mode == M_HALTED));
    if (m_valid) begin
      chk("model_instr", INSTR, m_instr);
      chk("model_instr_pc", 32'(INSTR_PC), 32'(m_ipc));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[5] = HALT;

    // Reset state
    RST = 1'b1; step();
    chk("rst_valid", 32'(INSTR_VALID), 32'd0);
    chk("rst_instr", INSTR, 32'd0);
    chk("rst_halted", 32'(HALTED), 32'd0);
    chk("rst_imem_a", 32'(IMEM_A), 32'd0);
    RST = 1'b0; step();
    chk("idle_no_fetch", 32'(INSTR_VALID), 32'd0);

    // Start and straight-line fetch
    START = 1'b1; ID_READY = 1'b1; step();
    chk("run_entry_valid", 32'(INSTR_VALID), 32'd0);
    START = 1'b0; step();
    chk("fetch0_instr", INSTR, 32'h11);
    chk("fetch0_pc", 32'(INSTR_PC), 32'd0);
    chk("fetch0_imem_a", 32'(IMEM_A), 32'd1);
    step();
    chk("fetch1_instr", INSTR, 32'h22);

    // Stall three cycles on 0x22
    ID_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", INSTR, 32'h22);
      chk("stall_pc", 32'(INSTR_PC), 32'd1);
      chk("stall_imem_a", 32'(IMEM_A), 32'd2);
    end
    ID_READY = 1'b1; step();
    chk("release_instr", INSTR, 32'h33);
    step();
    chk("fetch3_instr", INSTR, 32'h44);
    chk("fetch3_pc", 32'(INSTR_PC), 32'd3);

    // Redirect over an unaccepted instruction
    ID_READY = 1'b0; step();
    REDIRECT = 1'b1; REDIRECT_ADDR = 8'h40; step();
    chk("redir_flush", 32'(INSTR_VALID), 32'd0);
    chk("redir_imem_a", 32'(IMEM_A), 32'h40);
    REDIRECT = 1'b0; ID_READY = 1'b1; step();
    chk("redir_instr", INSTR, mem[8'h40]);
    chk("redir_pc", 32'(INSTR_PC), 32'h40);

    // Wrap FE, FF, 00, 01
    REDIRECT = 1'b1; REDIRECT_ADDR = 8'hFE; step();
    REDIRECT = 1'b0;
    step(); chk("wrap_fe", 32'(INSTR_PC), 32'hFE);
    step(); chk("wrap_ff", 32'(INSTR_PC), 32'hFF);
    step(); chk("wrap_00", 32'(INSTR_PC), 32'h00);
    step(); chk("wrap_01", 32'(INSTR_PC), 32'h01);

    // Halt at address 5
    REDIRECT = 1'b1; REDIRECT_ADDR = 8'h04; step();
    REDIRECT = 1'b0;
    step(); chk("pre_halt_pc", 32'(INSTR_PC), 32'd4);
    step();
    chk("halt_instr", INSTR, HALT);
    chk("halt_pc", 32'(INSTR_PC), 32'd5);
    chk("halt_flag", 32'(HALTED), 32'd1);
    chk("halt_imem_a", 32'(IMEM_A), 32'd5);
    START = 1'b1; step(); START = 1'b0;
    chk("halt_drained", 32'(INSTR_VALID), 32'd0);
    chk("halt_start_ignored", 32'(HALTED), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_quiet", 32'(INSTR_VALID), 32'd0);
      chk("halt_imem_hold", 32'(IMEM_A), 32'd5);
    end
    REDIRECT = 1'b1; REDIRECT_ADDR = 8'h00; step();
    REDIRECT = 1'b0;
    chk("halt_exit", 32'(HALTED), 32'd0);
    step();
    chk("refetch_instr", INSTR, 32'h11);
    chk("refetch_pc", 32'(INSTR_PC), 32'd0);

    // Mid-run reset while stalled
    ID_READY = 1'b0; step();
    chk("pre_rst_valid", 32'(INSTR_VALID), 32'd1);
    RST = 1'b1; step();
    chk("midrst_valid", 32'(INSTR_VALID), 32'd0);
    chk("midrst_instr", INSTR, 32'd0);
    chk("midrst_instr_pc", 32'(INSTR_PC), 32'd0);
    chk("midrst_imem_a", 32'(IMEM_A), 32'd0);
    chk("midrst_halted", 32'(HALTED), 32'd0);
    RST = 1'b0; ID_READY = 1'b1; step();
    chk("midrst_idle", 32'(INSTR_VALID), 32'd0);

    // Randomized traffic with sprinkled halt words
    for (int i = 0; i < 12; i++) mem[$urandom_range(0, 255)] = HALT;
    for (int i = 0; i < 600; i++) begin
      RST           = ($urandom_range(0, 59) == 0);
      START         = ($urandom_range(0, 7) == 0);
      REDIRECT      = ($urandom_range(0, 9) == 0);
      REDIRECT_ADDR = 8'($urandom);
      ID_READY      = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the 256x32 instruction memory. It drives the memory's 8-bit word address and captures the combinational 32-bit read data into an IF/ID register for the decoder.
- Holds the program counter and a start/run/halt state machine.
- Accepts redirects (branch/jump) from execute and back-pressure from decode via a valid/ready handshake.

Parameters:
- ADDR_W, 8, instruction word-address width; the memory depth is 2**ADDR_W words.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  one-cycle pulse; leaves IDLE.
- IMEM_A  out  ADDR_W  word address to the instruction memory; equals PC combinationally.
- IMEM_RD  in  DATA_W  combinational read data from the instruction memory.
- REDIRECT  in  1  execute requests a PC change this cycle.
- REDIRECT_ADDR  in  ADDR_W  new word address when REDIRECT=1.
- ID_READY  in  1  decoder accepts INSTR this cycle.
- INSTR  out  DATA_W  IF/ID instruction register.
- INSTR_PC  out  ADDR_W  address INSTR was fetched from.
- INSTR_VALID  out  1  INSTR holds a valid instruction.
- HALTED  out  1  state is HALTED.

Behaviour:
- States are IDLE, RUN and HALTED. RST (at an edge) takes priority over everything:
  - State becomes IDLE.
  - PC becomes RESET_PC.
  - INSTR, INSTR_PC and INSTR_VALID become 0.
  - HALTED is 0.
  - This applies when RST is asserted mid-operation too; no partial update survives.
- IMEM_A = PC in every state. There is no read latency, so IMEM_RD is sampled at the same edge the address is presented.
- Handshake:
  - A transfer to decode occurs when INSTR_VALID=1 and ID_READY=1.
  - "slot_free" = !INSTR_VALID | ID_READY.
  - While INSTR_VALID=1 and ID_READY=0, INSTR, INSTR_PC, INSTR_VALID and PC hold. INSTR must not change while valid and not accepted.
- IDLE:
  - No fetch; INSTR_VALID stays 0.
  - START=1 moves to RUN at the next edge. The first fetch happens in the first RUN cycle.
  - REDIRECT in IDLE loads PC = REDIRECT_ADDR and stays in IDLE.
- RUN, fetch cycle (slot_free=1 and REDIRECT=0):
  - INSTR <= IMEM_RD, INSTR_PC <= PC, INSTR_VALID <= 1.
  - PC <= PC+1, modulo 2**ADDR_W; 255 wraps to 0 at ADDR_W=8.
  - If IMEM_RD == HALT_WORD, the halt word is still delivered to decode (INSTR_VALID=1), PC does not increment, and state goes to HALTED.
- RUN, REDIRECT=1 (priority over fetch and stall):
  - PC <= REDIRECT_ADDR.
  - INSTR_VALID <= 0, flushing the wrong-path instruction even if it is unaccepted.
  - No fetch this cycle.
  - Next fetch is from REDIRECT_ADDR on the following cycle (one bubble).
- RUN, slot_free=0 and REDIRECT=0: full hold.
- HALTED:
  - No new fetches. HALTED=1.
  - The halt word stays valid until accepted, then INSTR_VALID <= 0.
  - REDIRECT=1 sets PC <= REDIRECT_ADDR, clears INSTR_VALID and returns to RUN.
  - START is ignored. Only reset or redirect exits HALTED.
- Simultaneous events:
  - RST > REDIRECT > fetch/stall.
  - START together with REDIRECT in IDLE: PC loads REDIRECT_ADDR and the state moves to RUN.
- All arithmetic is unsigned at ADDR_W bits. No overflow flag; wrap is silent.

Decomposition:
- Shared package or header holds:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, HALTED=2'd2 (2'd3 is illegal and recovers to IDLE).
  - The HALT_WORD default.
  - Width constants ADDR_W and DATA_W.
- One natural sub-module, pc_reg: PC register with load/increment/hold and wrap. The FSM and IF/ID register stay in the top.

Test Plan:
- Reset then START, memory words 0..3 = 32'h11,32'h22,32'h33,32'h44, ID_READY=1 -> INSTR_VALID rises one edge after entering RUN; INSTR sequence 11,22,33,44 with INSTR_PC 0,1,2,3; IMEM_A increments each cycle.
- Stall: hold ID_READY=0 for 3 cycles while INSTR=32'h22 -> INSTR, INSTR_PC=1, IMEM_A=2 all frozen; on release the next INSTR is 32'h33 and no word is lost or duplicated.
- Redirect to 8'h40 while an unaccepted instruction is valid -> INSTR_VALID=0 next cycle, then INSTR=mem[0x40] with INSTR_PC=0x40; the flushed word is never accepted.
- Wrap: REDIRECT_ADDR=8'hFE, run -> INSTR_PC sequence FE, FF, 00, 01.
- Halt: mem[5]=32'hFFFF_FFFF -> halt word delivered with INSTR_PC=5, HALTED=1, IMEM_A stays 5, no further valid output; START ignored; REDIRECT to 0 returns to RUN and refetches from 0.
- Mid-run RST with INSTR_VALID=1 and ID_READY=0 -> next edge gives state IDLE, PC=0, INSTR=0, INSTR_VALID=0, HALTED=0.
